ripple_count_sampler: RTL

RIPPLE_COUNT_SAMPLER -- requirements
Module: ripple_count_sampler

---
 rtl/ripple_count_sampler.sv | 138 +++++++++++++
 1 files changed

// File: rtl/ripple_count_sampler.sv
// Ripple-counter sampler: synchronize, debounce, accept, and hand off count events.
// Optional wrap counter output enabled by defining SAMPLER_WRAP_CNT_EN.
module ripple_count_sampler #(
  parameter int unsigned STABLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] cnt_in,
  input  logic [3:0] thresh,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [3:0] out_count,
  output logic       out_wrap,
  output logic       hit,
  output logic       overrun
`ifdef SAMPLER_WRAP_CNT_EN
  ,
  output logic [7:0] wrap_cnt
`endif
);

  localparam logic [2:0] RUN_MAX = 3'(STABLE_CYCLES);

  typedef enum logic {
    IDLE,
    HOLD
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] s1_q, s1_d;
  logic [3:0] s2_q, s2_d;
  logic [2:0] run_q, run_d;
  logic [3:0] last_acc_q, last_acc_d;
  logic [3:0] out_count_q, out_count_d;
  logic       out_wrap_q, out_wrap_d;
  logic       hit_q, hit_d;
  logic       overrun_q, overrun_d;
  logic       accept;
  logic       wrap;
  logic       load;

  // Synchronizer, run-length counter and acceptance decision.
  always_comb begin
    s1_d   = cnt_in;
    s2_d   = s1_q;
    run_d  = 3'd1;
    if (s1_q == s2_q) begin
      run_d = (run_q == RUN_MAX) ? run_q : run_q + 3'd1;
    end
    accept     = (run_q == RUN_MAX) && (s2_q != last_acc_q);
    wrap       = s2_q < last_acc_q;
    last_acc_d = accept ? s2_q : last_acc_q;
  end

  // Output register loading, hit and overrun pulses.
  always_comb begin
    load        = accept && ((state_q == IDLE) || out_ready);
    out_count_d = load ? s2_q : out_count_q;
    out_wrap_d  = load ? wrap : out_wrap_q;
    hit_d       = load && (s2_q == thresh);
    overrun_d   = accept && !load;
  end

  // Datapath state, cleared asynchronously on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q        <= '0;
      s2_q        <= '0;
      run_q       <= '0;
      last_acc_q  <= '0;
      out_count_q <= '0;
      out_wrap_q  <= 1'b0;
      hit_q       <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      run_q       <= run_d;
      last_acc_q  <= last_acc_d;
      out_count_q <= out_count_d;
      out_wrap_q  <= out_wrap_d;
      hit_q       <= hit_d;
      overrun_q   <= overrun_d;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: a new acceptance during handshake keeps HOLD.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = HOLD;
      HOLD: if (out_ready && !accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    out_valid = (state_q == HOLD);
    out_count = out_count_q;
    out_wrap  = out_wrap_q;
    hit       = hit_q;
    overrun   = overrun_q;
  end

`ifdef SAMPLER_WRAP_CNT_EN
  logic [7:0] wrap_cnt_q, wrap_cnt_d;

  // Saturating count of wrapping acceptances, dropped ones included.
  always_comb begin
    wrap_cnt_d = wrap_cnt_q;
    if (accept && wrap && (wrap_cnt_q != 8'hFF)) begin
      wrap_cnt_d = wrap_cnt_q + 8'd1;
    end
  end

  // Wrap counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrap_cnt_q <= '0;
    end else begin
      wrap_cnt_q <= wrap_cnt_d;
    end
  end

  assign wrap_cnt = wrap_cnt_q;
`endif

endmodule
